// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard/stall controller.
//   - md_state_t      : mult/div busy-timer FSM encoding (ST_RUN, ST_MD_WAIT)
//   - REG_ZERO        : architectural $zero register index
//   - DEFAULT_MULDIV_LATENCY : default mult/div latency in cycles
//   - sat_inc16()     : saturating 16-bit increment (used by the optional
//                       stall statistics, enabled with STALL_STATS_EN)
// ---------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } md_state_t;

    localparam logic [4:0] REG_ZERO               = 5'd0;
    localparam int         DEFAULT_MULDIV_LATENCY = 32;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/muldiv_busy_timer.sv
// ---------------------------------------------------------------------------
// muldiv_busy_timer
// Tracks an in-flight multiply/divide. A start pulse loads the counter with
// LATENCY-1 and moves to MD_WAIT; the counter then runs down and the FSM
// returns to RUN on the edge after it reads 1. o_busy is the registered
// state, so it is high for exactly LATENCY-1 cycles, beginning the cycle
// after the start pulse.
//
// Ports:
//   clk      in   core clock, rising edge
//   rst_n    in   asynchronous active-low reset (abandons any pending op)
//   i_start  in   one-cycle launch pulse (ignored while busy)
//   o_busy   out  result pending
//
// Parameters:
//   LATENCY  cycles from launch to HI/LO valid (>= 2)
//   CNT_W    counter width, 2**CNT_W > LATENCY
// ---------------------------------------------------------------------------
module muldiv_busy_timer
    import hazard_pkg::*;
#(
    parameter int LATENCY = DEFAULT_MULDIV_LATENCY,
    parameter int CNT_W   = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    output logic o_busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_state_t        r_state;
    md_state_t        w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            ST_RUN: begin
                if (i_start) begin
                    w_state_next = ST_MD_WAIT;
                    w_cnt_next   = CNT_LOAD;
                end
            end
            ST_MD_WAIT: begin
                // Last busy cycle: leave with a clean zero count.
                if (r_cnt == CNT_ONE) begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_next = ST_RUN;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign o_busy = (r_state == ST_MD_WAIT);

endmodule

// File: rtl/hazard_stall_controller.sv
// ---------------------------------------------------------------------------
// hazard_stall_controller
// Stall/flush sequencer for the five-stage MIPS pipeline. Handles the
// hazards forwarding cannot cover:
//   - load-use: one-cycle bubble (freeze PC and IF/ID, zero ID/EX controls)
//   - mult/div: owns the busy timer and stalls mult/div and HI/LO users in
//     ID until the previous result is ready
//   - taken branch resolved in EX: flush IF/ID and ID/EX (highest priority)
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   ID_EX_MemRead/RegisterRt    load in EX and its destination
//   IF_ID_RegisterRs/Rt/UsesRt  source registers of the ID instruction
//   ID_MulDivOp, ID_ReadsHiLo   ID instruction class
//   EX_BranchTaken              taken branch/jump in EX
//   PCWrite, IF_ID_Write        pipeline enables
//   IF_ID_Flush, ID_EX_Bubble   squash controls
//   MulDivStart, MulDivBusy     mult/div launch pulse and pending flag
//   LoadStallCount, MdStallCount  saturating stall counters
//                               (only when STALL_STATS_EN is defined)
//
// Build option: define STALL_STATS_EN to add the stall statistic counters.
// ---------------------------------------------------------------------------
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int MULDIV_LATENCY = DEFAULT_MULDIV_LATENCY,
    parameter int CNT_W          = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_RegisterRt,
    input  logic [4:0]  IF_ID_RegisterRs,
    input  logic [4:0]  IF_ID_RegisterRt,
    input  logic        IF_ID_UsesRt,
    input  logic        ID_MulDivOp,
    input  logic        ID_ReadsHiLo,
    input  logic        EX_BranchTaken,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Bubble,
    output logic        MulDivStart,
`ifdef STALL_STATS_EN
    output logic        MulDivBusy,
    output logic [15:0] LoadStallCount,
    output logic [15:0] MdStallCount
`else
    output logic        MulDivBusy
`endif
);

    logic w_load_use;
    logic w_md_hazard;
    logic w_stall;
    logic w_busy;

    // A load into $zero never produces a usable value, so it cannot hazard.
    assign w_load_use = ID_EX_MemRead
                      && (ID_EX_RegisterRt != REG_ZERO)
                      && ((ID_EX_RegisterRt == IF_ID_RegisterRs)
                          || (IF_ID_UsesRt && (ID_EX_RegisterRt == IF_ID_RegisterRt)));

    assign w_md_hazard = w_busy && (ID_MulDivOp || ID_ReadsHiLo);
    assign w_stall     = w_load_use || w_md_hazard;

    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        MulDivStart  = 1'b0;
        if (EX_BranchTaken) begin
            // The ID instruction is squashed, so any stall it wanted is moot
            // and a mult/div sitting there must not launch.
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
        end else if (w_stall) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end else begin
            MulDivStart  = ID_MulDivOp;
        end
    end

    muldiv_busy_timer #(
        .LATENCY (MULDIV_LATENCY),
        .CNT_W   (CNT_W)
    ) u_muldiv_busy_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (MulDivStart),
        .o_busy  (w_busy)
    );

    assign MulDivBusy = w_busy;

`ifdef STALL_STATS_EN
    logic [15:0] r_load_stall_cnt;
    logic [15:0] r_md_stall_cnt;

    // Only cycles that actually stall count; a branch override wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_stall_cnt <= '0;
            r_md_stall_cnt   <= '0;
        end else if (!EX_BranchTaken) begin
            if (w_load_use) begin
                r_load_stall_cnt <= sat_inc16(r_load_stall_cnt);
            end
            if (w_md_hazard) begin
                r_md_stall_cnt <= sat_inc16(r_md_stall_cnt);
            end
        end
    end

    assign LoadStallCount = r_load_stall_cnt;
    assign MdStallCount   = r_md_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_controller
// Directed self-checking bench for hazard_stall_controller with
// MULDIV_LATENCY=4. Inputs change 1 time unit after the rising edge and
// outputs are sampled on the falling edge. Statistic-counter checks are
// compiled only when STALL_STATS_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hazard_stall_controller;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ID_EX_MemRead;
    logic [4:0] ID_EX_RegisterRt;
    logic [4:0] IF_ID_RegisterRs;
    logic [4:0] IF_ID_RegisterRt;
    logic       IF_ID_UsesRt;
    logic       ID_MulDivOp;
    logic       ID_ReadsHiLo;
    logic       EX_BranchTaken;
    logic       PCWrite;
    logic       IF_ID_Write;
    logic       IF_ID_Flush;
    logic       ID_EX_Bubble;
    logic       MulDivStart;
    logic       MulDivBusy;
`ifdef STALL_STATS_EN
    logic [15:0] LoadStallCount;
    logic [15:0] MdStallCount;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    hazard_stall_controller #(
        .MULDIV_LATENCY (LAT),
        .CNT_W          (6)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ID_EX_MemRead    (ID_EX_MemRead),
        .ID_EX_RegisterRt (ID_EX_RegisterRt),
        .IF_ID_RegisterRs (IF_ID_RegisterRs),
        .IF_ID_RegisterRt (IF_ID_RegisterRt),
        .IF_ID_UsesRt     (IF_ID_UsesRt),
        .ID_MulDivOp      (ID_MulDivOp),
        .ID_ReadsHiLo     (ID_ReadsHiLo),
        .EX_BranchTaken   (EX_BranchTaken),
        .PCWrite          (PCWrite),
        .IF_ID_Write      (IF_ID_Write),
        .IF_ID_Flush      (IF_ID_Flush),
        .ID_EX_Bubble     (ID_EX_Bubble),
        .MulDivStart      (MulDivStart),
`ifdef STALL_STATS_EN
        .MulDivBusy       (MulDivBusy),
        .LoadStallCount   (LoadStallCount),
        .MdStallCount     (MdStallCount)
`else
        .MulDivBusy       (MulDivBusy)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    // Pack the five combinational controls as {PCWrite,IF_ID_Write,Flush,Bubble,Start}.
    function automatic logic [31:0] ctl();
        return {27'd0, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MulDivStart};
    endfunction

    localparam logic [31:0] CTL_RUN    = 32'b11000;
    localparam logic [31:0] CTL_STALL  = 32'b00010;
    localparam logic [31:0] CTL_FLUSH  = 32'b11110;
    localparam logic [31:0] CTL_LAUNCH = 32'b11001;

    task automatic idle_inputs();
        ID_EX_MemRead    = 1'b0;
        ID_EX_RegisterRt = 5'd0;
        IF_ID_RegisterRs = 5'd0;
        IF_ID_RegisterRt = 5'd0;
        IF_ID_UsesRt     = 1'b0;
        ID_MulDivOp      = 1'b0;
        ID_ReadsHiLo     = 1'b0;
        EX_BranchTaken   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    int stalls;
    int busy_cycles;
    int launch_seen;

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        sample();
        check_eq("reset_ctl", ctl(), CTL_RUN);
        check_eq("reset_busy", 32'(MulDivBusy), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        sample();
        check_eq("after_reset_ctl", ctl(), CTL_RUN);

        // lw $2 in EX, ID reads rs=$2 -> one bubble
        step();
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd2; IF_ID_RegisterRs = 5'd2;
        sample();
        check_eq("lu_rs_stall", ctl(), CTL_STALL);
        step();
        ID_EX_MemRead = 1'b0;   // bubble has cleared the load from EX
        sample();
        check_eq("lu_rs_release", ctl(), CTL_RUN);

        // lw $0 never stalls
        step();
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd0; IF_ID_RegisterRs = 5'd0;
        sample();
        check_eq("lu_zero_nostall", ctl(), CTL_RUN);

        // lw $5, ID rt=$5 but rt not a source -> no stall; as a source -> stall
        step();
        ID_EX_RegisterRt = 5'd5; IF_ID_RegisterRs = 5'd3; IF_ID_RegisterRt = 5'd5; IF_ID_UsesRt = 1'b0;
        sample();
        check_eq("lu_rt_unused", ctl(), CTL_RUN);
        step();
        IF_ID_UsesRt = 1'b1;
        sample();
        check_eq("lu_rt_used", ctl(), CTL_STALL);

        // load-use together with a taken branch -> flush wins
        step();
        ID_EX_RegisterRt = 5'd2; IF_ID_RegisterRs = 5'd2; EX_BranchTaken = 1'b1;
        sample();
        check_eq("branch_over_lu", ctl(), CTL_FLUSH);
        step();
        idle_inputs();

        // mult launch, then mfhi held in ID: expect 3 stall cycles
        ID_MulDivOp = 1'b1;
        sample();
        check_eq("md_launch", ctl(), CTL_LAUNCH);
        check_eq("md_busy_at_launch", 32'(MulDivBusy), 32'd0);
        step();
        ID_MulDivOp = 1'b0; ID_ReadsHiLo = 1'b1;
        stalls = 0; busy_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            sample();
            if (MulDivBusy) busy_cycles++;
            if (!PCWrite) stalls++;
            else break;
            step();
        end
        check_eq("mfhi_stall_cycles", 32'(stalls), LAT - 1);
        check_eq("md_busy_cycles", 32'(busy_cycles), LAT - 1);
        check_eq("mfhi_pass_ctl", ctl(), CTL_RUN);
        step();
        idle_inputs();

        // back-to-back mult: second waits, launches in first non-busy cycle
        ID_MulDivOp = 1'b1;
        step();
        stalls = 0; launch_seen = 0;
        for (int i = 0; i < 10; i++) begin
            sample();
            if (MulDivStart) begin
                launch_seen = 1;
                check_eq("b2b_launch_busy", 32'(MulDivBusy), 32'd0);
                break;
            end
            if (!PCWrite) stalls++;
            step();
        end
        check_eq("b2b_launched", 32'(launch_seen), 32'd1);
        check_eq("b2b_stall_cycles", 32'(stalls), LAT - 1);
        step();
        ID_MulDivOp = 1'b0;

        // branch during busy does not cancel; busy remains LAT-1 cycles total
        EX_BranchTaken = 1'b1;
        busy_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            sample();
            if (i == 0) check_eq("branch_while_busy", ctl(), CTL_FLUSH);
            if (MulDivBusy) busy_cycles++;
            else break;
            step();
            EX_BranchTaken = 1'b0;
        end
        check_eq("busy_through_branch", 32'(busy_cycles), LAT - 1);
        step();
        idle_inputs();

        // branch squashes a mult in ID: no launch
        ID_MulDivOp = 1'b1; EX_BranchTaken = 1'b1;
        sample();
        check_eq("branch_kills_start", ctl(), CTL_FLUSH);
        step();
        check_eq("no_busy_after_squash", 32'(MulDivBusy), 32'd0);
        EX_BranchTaken = 1'b0;

        // async reset mid MD_WAIT (cnt=2)
        sample();
        check_eq("launch_before_reset", 32'(MulDivStart), 32'd1);
        step();                 // cnt=3
        ID_MulDivOp = 1'b0;
        step();                 // cnt=2
        check_eq("busy_before_reset", 32'(MulDivBusy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("busy_async_clear", 32'(MulDivBusy), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        sample();
        check_eq("busy_after_release", 32'(MulDivBusy), 32'd0);
        step();
        ID_MulDivOp = 1'b1;
        sample();
        check_eq("relaunch_ctl", ctl(), CTL_LAUNCH);
        step();
        ID_MulDivOp = 1'b0;
        sample();
        check_eq("relaunch_busy", 32'(MulDivBusy), 32'd1);
        for (int i = 0; i < 10 && MulDivBusy; i++) step();
        idle_inputs();

`ifdef STALL_STATS_EN
        rst_n = 1'b0;
        #2;
        check_eq("stats_reset_load", 32'(LoadStallCount), 32'd0);
        check_eq("stats_reset_md", 32'(MdStallCount), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        // 3 load-use stall cycles, plus one branch-overridden that must not count
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd7; IF_ID_RegisterRs = 5'd7;
        for (int i = 0; i < 3; i++) step();
        EX_BranchTaken = 1'b1;
        step();
        idle_inputs();
        // launch, then mfhi for exactly 2 of the 3 busy cycles
        ID_MulDivOp = 1'b1;
        step();
        ID_MulDivOp = 1'b0; ID_ReadsHiLo = 1'b1;
        step();
        step();
        ID_ReadsHiLo = 1'b0;
        step();
        step();
        sample();
        check_eq("stats_load", 32'(LoadStallCount), 32'd3);
        check_eq("stats_md", 32'(MdStallCount), 32'd2);
        // saturation
        step();
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd7; IF_ID_RegisterRs = 5'd7;
        for (int i = 0; i < 65540; i++) step();
        idle_inputs();
        sample();
        check_eq("stats_load_sat", 32'(LoadStallCount), 32'hFFFF);
        check_eq("stats_md_held", 32'(MdStallCount), 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Sequences pipeline stalls and flushes for the five-stage MIPS core; works alongside the forwarding logic, covering the hazards forwarding cannot resolve.
- Inserts a one-cycle bubble on load-use.
- Owns a multi-cycle multiply/divide busy counter and stalls HI/LO consumers until the result is ready.
- Flushes IF/ID and ID/EX on a taken branch resolved in EX.
- Sits between ID-stage decode and the PC, IF/ID and ID/EX register enables.

Parameters:
MULDIV_LATENCY, 32, cycles from mult/div launch until HI/LO valid (>=2)
CNT_W, 6, busy-counter width; must satisfy 2**CNT_W > MULDIV_LATENCY

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
ID_EX_MemRead  input  1  instruction in EX is a load
ID_EX_RegisterRt  input  5  load destination register in EX
IF_ID_RegisterRs  input  5  rs of instruction in ID
IF_ID_RegisterRt  input  5  rt of instruction in ID
IF_ID_UsesRt  input  1  ID instruction reads rt as a source
ID_MulDivOp  input  1  ID instruction is mult/multu/div/divu
ID_ReadsHiLo  input  1  ID instruction is mfhi/mflo/mthi/mtlo
EX_BranchTaken  input  1  branch/jump resolved taken in EX this cycle
PCWrite  output  1  PC update enable
IF_ID_Write  output  1  IF/ID register enable
IF_ID_Flush  output  1  clear IF/ID to nop
ID_EX_Bubble  output  1  zero ID/EX control fields
MulDivStart  output  1  one-cycle launch pulse to mult/div unit
MulDivBusy  output  1  mult/div result pending

Behaviour:
- States: RUN, MD_WAIT. Busy counter `cnt[CNT_W-1:0]`.
- Reset (async, rst_n=0): state=RUN, cnt=0.
  - Outputs during and after reset: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Bubble=0, MulDivStart=0, MulDivBusy=0.
  - Reset mid-operation abandons any pending mult/div without a completion pulse.
- Hazard terms (combinational):
  - load_use = ID_EX_MemRead & ID_EX_RegisterRt!=0 & (ID_EX_RegisterRt==IF_ID_RegisterRs | (IF_ID_UsesRt & ID_EX_RegisterRt==IF_ID_RegisterRt)).
  - md_hazard = MulDivBusy & (ID_MulDivOp | ID_ReadsHiLo).
- Priority 1, EX_BranchTaken:
  - IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1, IF_ID_Write=1.
  - Overrides load_use and md_hazard.
  - MulDivStart=0, since the ID instruction is squashed.
- Priority 2, stall = load_use | md_hazard:
  - PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0, MulDivStart=0.
- Otherwise all enables are 1 and bubble/flush are 0.
- MulDivStart=1 iff ID_MulDivOp & no branch & no stall. All outputs except MulDivBusy are combinational.
- RUN: on MulDivStart go to MD_WAIT with cnt=MULDIV_LATENCY-1.
- MD_WAIT: cnt decrements each cycle.
  - At cnt==1, return to RUN with cnt=0 on the next edge.
  - MulDivBusy = (state==MD_WAIT), registered. It is high exactly MULDIV_LATENCY-1 cycles, starting the cycle after the launch.
  - A branch flush does not cancel an in-flight mult/div; the counter continues.
- Load-use stall lasts exactly one cycle: the bubble clears ID_EX_MemRead on the next edge. A load to $0 never stalls.
- A back-to-back mult/div in ID while busy stalls, then launches in the first cycle MulDivBusy=0.

Optional Feature:
STALL_STATS_EN
- Defined: adds outputs LoadStallCount[15:0] and MdStallCount[15:0].
  - Each is a saturating (hold at 16'hFFFF) counter, incremented on every cycle where load_use, respectively md_hazard, causes a stall (branch-overridden cycles are not counted).
  - Both clear on rst_n=0. When both hazards are true in the same cycle, both counters increment.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package `hazard_pkg`: state encoding constants (ST_RUN, ST_MD_WAIT), REG_ZERO=5'd0, and the default MULDIV_LATENCY constant.
- One natural sub-module: `muldiv_busy_timer`, holding the counter and MD_WAIT FSM. Interface: start in, busy out, parameterised by latency.
- Hazard detection and output muxing stay in the top level.

Test Plan:
- lw $2 in EX (MemRead=1, Rt=2), ID Rs=2 -> one cycle PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1; next cycle with MemRead=0 all enables are 1.
- lw $0 in EX, ID Rs=0; and lw $5 in EX, ID Rt=5 with UsesRt=0 -> no stall.
- MULDIV_LATENCY=4, ID_MulDivOp=1 -> MulDivStart pulses once, MulDivBusy high 3 cycles; mfhi held in ID stalls exactly 3 cycles, then passes.
- Load-use and EX_BranchTaken in the same cycle -> IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1, no stall.
- Assert rst_n=0 asynchronously mid-MD_WAIT (cnt=2) -> MulDivBusy drops immediately with no clock edge; after release the state is RUN and a new launch works.
- With STALL_STATS_EN: 3 load-use cycles plus 2 md stalls -> LoadStallCount=3, MdStallCount=2; forced to 16'hFFFF, the counters hold.
